// File: rtl/ethernet_header_pkg.sv
// Shared Ethernet TX types: arbiter state encoding, reused by monitors.
package ethernet_header_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    PAD   = 2'd2,
    DRAIN = 2'd3
  } tx_arb_state_t;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// Combinational requester pick: wrap search from ptr (round robin), or
// lowest-index-wins when ETH_TX_ARB_FIXED_PRIO_EN is defined.
module tx_rr_pick
  import ethernet_header_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IDX_W = idx_width(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  // Scan from the top down so the lowest valid index is written last.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_idx = IDX_W'(i);
        any     = 1'b1;
      end
    end
  end
`else
  // First requester at or after ptr, wrapping modulo NUM_SRC.
  always_comb begin
    int idx;
    gnt_idx = '0;
    any     = 1'b0;
    idx     = 0;
    for (int k = 0; k < int'(NUM_SRC); k++) begin
      idx = (int'(ptr) + k) % int'(NUM_SRC);
      if (!any && req[idx]) begin
        gnt_idx = IDX_W'(idx);
        any     = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/eth_tx_arbiter.sv
// Packet-granular arbiter feeding a fixed-length Ethernet transmitter.
// Each emitted packet is exactly PACKET_PAYLOAD_WORDS beats: short packets
// are zero-padded, long ones truncated and the remainder drained.
// Build option: ETH_TX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module eth_tx_arbiter
  import ethernet_header_pkg::*;
#(
  parameter int unsigned NUM_SRC              = 4,
  parameter int unsigned WORD_BYTES           = 1,
  parameter int unsigned PACKET_PAYLOAD_WORDS = 64,
  localparam int unsigned DATA_W  = WORD_BYTES * 8,
  localparam int unsigned GRANT_W = idx_width(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]        s_axis_tvalid,
  input  logic [NUM_SRC-1:0]        s_axis_tlast,
  output logic [NUM_SRC-1:0]        s_axis_tready,
  output logic [DATA_W-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic [GRANT_W-1:0]        grant_id,
  output logic                      busy,
  output logic                      pad_pulse,
  output logic                      trunc_pulse
);

  localparam int unsigned CNT_W = $clog2(PACKET_PAYLOAD_WORDS + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PACKET_PAYLOAD_WORDS - 1);

  tx_arb_state_t     state, state_next;
  logic [GRANT_W-1:0] grant_next, pick_idx, ptr;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               pad_next, trunc_next, pick_any;
  logic               src_valid, src_last, at_last;
  logic [DATA_W-1:0]  src_data;

`ifndef ETH_TX_ARB_FIXED_PRIO_EN
  logic [GRANT_W-1:0] rr_ptr, rr_ptr_next;
  assign ptr = rr_ptr;
`else
  assign ptr = '0;
`endif

  tx_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
    .req     (s_axis_tvalid),
    .ptr     (ptr),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Granted source view, combinational for zero-latency forwarding.
  assign src_valid = s_axis_tvalid[grant_id];
  assign src_last  = s_axis_tlast[grant_id];
  assign src_data  = s_axis_tdata[grant_id*DATA_W +: DATA_W];
  assign at_last   = (cnt == LAST_BEAT);
  assign busy      = (state != IDLE);

  // Next-state, handshake routing and beat normalisation.
  always_comb begin
    state_next    = state;
    grant_next    = grant_id;
    cnt_next      = cnt;
    pad_next      = 1'b0;
    trunc_next    = 1'b0;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
`ifndef ETH_TX_ARB_FIXED_PRIO_EN
    rr_ptr_next   = rr_ptr;
`endif
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (pick_any) begin
          grant_next = pick_idx;
          state_next = FWD;
`ifndef ETH_TX_ARB_FIXED_PRIO_EN
          rr_ptr_next = GRANT_W'((int'(pick_idx) + 1) % int'(NUM_SRC));
`endif
        end
      end
      FWD: begin
        m_axis_tdata            = src_data;
        m_axis_tvalid           = src_valid;
        m_axis_tlast            = at_last;
        s_axis_tready[grant_id] = m_axis_tready;
        if (src_valid && m_axis_tready) begin
          cnt_next = cnt + CNT_W'(1);
          if (src_last && at_last) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else if (src_last) begin
            state_next = PAD;
            pad_next   = 1'b1;
          end else if (at_last) begin
            state_next = DRAIN;
            trunc_next = 1'b1;
          end
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = at_last;
        if (m_axis_tready) begin
          cnt_next = cnt + CNT_W'(1);
          if (at_last) begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      DRAIN: begin
        s_axis_tready[grant_id] = 1'b1;
        if (src_valid && src_last) begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      end
    endcase
  end

  // State, grant, beat counter and event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant_id    <= '0;
      cnt         <= '0;
      pad_pulse   <= 1'b0;
      trunc_pulse <= 1'b0;
`ifndef ETH_TX_ARB_FIXED_PRIO_EN
      rr_ptr      <= '0;
`endif
    end else begin
      state       <= state_next;
      grant_id    <= grant_next;
      cnt         <= cnt_next;
      pad_pulse   <= pad_next;
      trunc_pulse <= trunc_next;
`ifndef ETH_TX_ARB_FIXED_PRIO_EN
      rr_ptr      <= rr_ptr_next;
`endif
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter (NUM_SRC=4, 4-beat packets).
module tb_eth_tx_arbiter;

  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned PPW     = 4;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } beat_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [1:0] gid;
    logic       pad;
    logic [1:0] trig;   // 1: pad trigger beat, 2: truncation beat
  } exp_t;

  logic                 clk, rst;
  logic [NUM_SRC*8-1:0] s_data;
  logic [NUM_SRC-1:0]   s_valid, s_last, s_ready;
  logic [7:0]           m_data;
  logic                 m_valid, m_last, m_ready;
  logic [1:0]           grant_id;
  logic                 busy, pad_pulse, trunc_pulse;

  beat_t src_q [NUM_SRC][$];
  exp_t  exp_q [$];

  int errors = 0;
  int checks = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: hold low
  int out_beats, tlast_cnt, pad_cnt, trunc_cnt;
  logic exp_pad_nxt, exp_trunc_nxt, prev_last, prev_trunc;

  eth_tx_arbiter #(
    .NUM_SRC(NUM_SRC), .WORD_BYTES(1), .PACKET_PAYLOAD_WORDS(PPW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tlast(s_last),
    .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tlast(m_last),
    .m_axis_tready(m_ready),
    .grant_id(grant_id), .busy(busy),
    .pad_pulse(pad_pulse), .trunc_pulse(trunc_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Queue a source packet and the normalised output beats it should produce.
  task automatic send_pkt(input int src, input int n, input logic [7:0] base);
    beat_t b;
    exp_t  e;
    for (int k = 0; k < n; k++) begin
      b.data = base + 8'(k);
      b.last = (k == n - 1);
      src_q[src].push_back(b);
      if (k < int'(PPW)) begin
        e.data = b.data;
        e.last = (k == int'(PPW) - 1);
        e.gid  = 2'(src);
        e.pad  = 1'b0;
        e.trig = (k == n - 1 && n < int'(PPW)) ? 2'd1 :
                 (k == int'(PPW) - 1 && n > int'(PPW)) ? 2'd2 : 2'd0;
        exp_q.push_back(e);
      end
    end
    for (int k = n; k < int'(PPW); k++) begin
      e.data = 8'h00;
      e.last = (k == int'(PPW) - 1);
      e.gid  = 2'(src);
      e.pad  = 1'b1;
      e.trig = 2'd0;
      exp_q.push_back(e);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < int'(NUM_SRC); i++)
      if (src_q[i].size() != 0) return 1'b0;
    return exp_q.size() == 0;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    ready_mode = 0;
    for (int i = 0; i < int'(NUM_SRC); i++) src_q[i].delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    out_beats = 0; tlast_cnt = 0; pad_cnt = 0; trunc_cnt = 0;
  endtask

  task automatic drain(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      #2;
      if (all_empty()) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Source drivers, sink ready pattern, and output scoreboard.
  initial begin
    m_ready = 1'b1;
    s_valid = '0; s_last = '0; s_data = '0;
    exp_pad_nxt = 0; exp_trunc_nxt = 0; prev_last = 0; prev_trunc = 0;
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'b0;
      endcase
      for (int i = 0; i < int'(NUM_SRC); i++) begin
        if (src_q[i].size() > 0) begin
          s_valid[i] = 1'b1;
          s_last[i]  = src_q[i][0].last;
          s_data[i*8 +: 8] = src_q[i][0].data;
        end else begin
          s_valid[i] = 1'b0;
          s_last[i]  = 1'b0;
          s_data[i*8 +: 8] = 8'h00;
        end
      end
      #1;
      if (rst) begin
        exp_pad_nxt = 0; exp_trunc_nxt = 0; prev_last = 0; prev_trunc = 0;
      end else begin
        checks++;
        if (pad_pulse !== exp_pad_nxt) begin
          errors++;
          $display("FAIL pad_pulse: got %b want %b at %0t", pad_pulse, exp_pad_nxt, $time);
        end
        checks++;
        if (trunc_pulse !== exp_trunc_nxt) begin
          errors++;
          $display("FAIL trunc_pulse: got %b want %b at %0t", trunc_pulse, exp_trunc_nxt, $time);
        end
        if (prev_last) begin
          checks++;
          if (m_valid !== 1'b0) begin
            errors++;
            $display("FAIL gap_valid: got %b want 0 at %0t", m_valid, $time);
          end
          checks++;
          if (busy !== prev_trunc) begin
            errors++;
            $display("FAIL gap_busy: got %b want %b at %0t", busy, prev_trunc, $time);
          end
        end
        pad_cnt   += int'(pad_pulse === 1'b1);
        trunc_cnt += int'(trunc_pulse === 1'b1);
        exp_pad_nxt = 0; exp_trunc_nxt = 0; prev_last = 0; prev_trunc = 0;
        if (m_valid === 1'b1 && exp_q.size() > 0) begin
          exp_t h;
          logic [NUM_SRC-1:0] want;
          h = exp_q[0];
          want = '0;
          if (!h.pad && m_ready) want[h.gid] = 1'b1;
          checks++;
          if (s_ready !== want) begin
            errors++;
            $display("FAIL s_ready: got %b want %b at %0t", s_ready, want, $time);
          end
        end
        if (m_valid === 1'b1 && m_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL extra_beat: got data %h with empty scoreboard at %0t", m_data, $time);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            checks += 3;
            if (m_data !== e.data) begin
              errors++;
              $display("FAIL out_data: got %h want %h at %0t", m_data, e.data, $time);
            end
            if (m_last !== e.last) begin
              errors++;
              $display("FAIL out_last: got %b want %b at %0t", m_last, e.last, $time);
            end
            if (grant_id !== e.gid) begin
              errors++;
              $display("FAIL grant_id: got %0d want %0d at %0t", grant_id, e.gid, $time);
            end
            exp_pad_nxt   = (e.trig == 2'd1);
            exp_trunc_nxt = (e.trig == 2'd2);
            prev_last     = e.last;
            prev_trunc    = (e.trig == 2'd2);
            out_beats++;
            if (e.last) tlast_cnt++;
          end
        end
        for (int i = 0; i < int'(NUM_SRC); i++)
          if (s_valid[i] && s_ready[i] === 1'b1 && src_q[i].size() > 0)
            void'(src_q[i].pop_front());
      end
    end
  end

  task automatic test_reset();
    do_reset();
    #2;
    checks += 7;
    if (m_valid !== 1'b0)  begin errors++; $display("FAIL rst_m_valid: got %b want 0", m_valid); end
    if (m_last !== 1'b0)   begin errors++; $display("FAIL rst_m_last: got %b want 0", m_last); end
    if (s_ready !== 4'b0)  begin errors++; $display("FAIL rst_s_ready: got %b want 0000", s_ready); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: got %0d want 0", grant_id); end
    if (pad_pulse !== 1'b0)   begin errors++; $display("FAIL rst_pad: got %b want 0", pad_pulse); end
    if (trunc_pulse !== 1'b0) begin errors++; $display("FAIL rst_trunc: got %b want 0", trunc_pulse); end
  endtask

  task automatic test_alternate();
    bit ok;
    do_reset();
    for (int p = 0; p < 3; p++) begin
      send_pkt(0, 4, 8'h10 + 8'(p * 16));
      send_pkt(2, 4, 8'h20 + 8'(p * 16));
    end
    drain(400, ok);
    checks += 3;
    if (!ok) begin errors++; $display("FAIL alt_timeout: got incomplete want drained"); end
    if (tlast_cnt != 6 || out_beats != 24) begin
      errors++; $display("FAIL alt_counts: got %0d pkts %0d beats want 6 24", tlast_cnt, out_beats);
    end
    if (pad_cnt != 0 || trunc_cnt != 0) begin
      errors++; $display("FAIL alt_pulses: got pad %0d trunc %0d want 0 0", pad_cnt, trunc_cnt);
    end
  endtask

  task automatic test_pad();
    bit ok;
    do_reset();
    send_pkt(1, 2, 8'hA1);
    drain(100, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL pad_timeout: got incomplete want drained"); end
    if (pad_cnt != 1 || trunc_cnt != 0 || tlast_cnt != 1) begin
      errors++;
      $display("FAIL pad_counts: got pad %0d trunc %0d pkts %0d want 1 0 1", pad_cnt, trunc_cnt, tlast_cnt);
    end
  endtask

  task automatic test_trunc();
    bit ok;
    do_reset();
    send_pkt(3, 6, 8'h31);
    drain(100, ok);
    @(negedge clk);
    #2;
    checks += 3;
    if (!ok) begin errors++; $display("FAIL trunc_timeout: got incomplete want drained"); end
    if (trunc_cnt != 1 || pad_cnt != 0 || out_beats != 4) begin
      errors++;
      $display("FAIL trunc_counts: got trunc %0d pad %0d beats %0d want 1 0 4", trunc_cnt, pad_cnt, out_beats);
    end
    if (busy !== 1'b0) begin errors++; $display("FAIL trunc_busy_end: got %b want 0", busy); end
  endtask

  task automatic test_toggle();
    bit ok;
    do_reset();
    ready_mode = 1;
    send_pkt(1, 3, 8'h50);
    send_pkt(2, 4, 8'h60);
    drain(200, ok);
    ready_mode = 0;
    checks += 2;
    if (!ok) begin errors++; $display("FAIL toggle_timeout: got incomplete want drained"); end
    if (out_beats != 8 || pad_cnt != 1) begin
      errors++; $display("FAIL toggle_counts: got %0d beats pad %0d want 8 1", out_beats, pad_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit hit;
    do_reset();
    send_pkt(1, 4, 8'hC0);
    hit = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #2;
      if (out_beats >= 2) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL mid_reach: got %0d beats want 2", out_beats); end
    @(negedge clk);
    ready_mode = 2;
    rst = 1'b1;
    for (int i = 0; i < int'(NUM_SRC); i++) src_q[i].delete();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    out_beats = 0; tlast_cnt = 0; pad_cnt = 0; trunc_cnt = 0;
    #2;
    checks += 5;
    if (m_valid !== 1'b0)  begin errors++; $display("FAIL mid_m_valid: got %b want 0", m_valid); end
    if (m_last !== 1'b0)   begin errors++; $display("FAIL mid_m_last: got %b want 0", m_last); end
    if (s_ready !== 4'b0)  begin errors++; $display("FAIL mid_s_ready: got %b want 0000", s_ready); end
    if (busy !== 1'b0)     begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL mid_grant: got %0d want 0", grant_id); end
    send_pkt(0, 4, 8'h70);
    send_pkt(3, 4, 8'h80);
    drain(100, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL mid_timeout: got incomplete want drained"); end
    if (tlast_cnt != 2) begin errors++; $display("FAIL mid_pkts: got %0d want 2", tlast_cnt); end
  endtask

`ifdef ETH_TX_ARB_FIXED_PRIO_EN
  task automatic test_fixed_prio();
    bit ok;
    do_reset();
    for (int p = 0; p < 3; p++) send_pkt(0, 4, 8'h40 + 8'(p * 4));
    send_pkt(3, 4, 8'h90);
    drain(200, ok);
    checks += 2;
    if (!ok) begin errors++; $display("FAIL fixed_timeout: got incomplete want drained"); end
    if (tlast_cnt != 4) begin errors++; $display("FAIL fixed_pkts: got %0d want 4", tlast_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1;
    test_reset();
    test_alternate();
    test_pad();
    test_trunc();
    test_toggle();
    test_reset_mid();
`ifdef ETH_TX_ARB_FIXED_PRIO_EN
    test_fixed_prio();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
